// File: rtl/peak_meter_mc.sv
// ---------------------------------------------------------------------------
// peak_meter_mc
// Multi-channel peak-hold level meter for the audio path. Each channel takes
// a saturating absolute value of its sample, captures new peaks, holds them
// for a while, then lets them decay exponentially back to zero. A sticky
// clip flag per channel catches full-scale samples. The bar display shows
// either the loudest channel or one selected channel as a thermometer code.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high; clears everything
//   audio_in     NUM_CH signed samples, channel c at [c*DATA_W +: DATA_W]
//   audio_valid  one strobe per sample frame; all meter state advances on it
//   clear        synchronous clear of peaks, hold/decay and clip state
//   disp_max     1: bar shows max over channels, 0: bar shows disp_ch
//   disp_ch      displayed channel when disp_max=0 (out of range -> 0)
//   led_level    registered thermometer bar, LSB = lowest segment
//   peak_out     registered displayed peak magnitude
//   clip         per-channel clip flag
// ---------------------------------------------------------------------------
module peak_meter_mc #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 32,
  parameter int NUM_LEDS      = 10,
  parameter int BASE_BIT      = 19,
  parameter int HOLD_SAMPLES  = 4800,
  parameter int DECAY_SAMPLES = 48,
  parameter int DECAY_SHIFT   = 4,
  parameter int CLIP_HOLD     = 24000,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] audio_in,
  input  logic                     audio_valid,
  input  logic                     clear,
  input  logic                     disp_max,
  input  logic [CH_W-1:0]          disp_ch,
  output logic [NUM_LEDS-1:0]      led_level,
  output logic [DATA_W-2:0]        peak_out,
  output logic [NUM_CH-1:0]        clip
);

  localparam int MAG_W   = DATA_W - 1;
  localparam int HOLD_W  = (HOLD_SAMPLES  > 1) ? $clog2(HOLD_SAMPLES)  : 1;
  localparam int DECAY_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam int CLIP_W  = (CLIP_HOLD     > 1) ? $clog2(CLIP_HOLD)     : 1;

  localparam logic [MAG_W-1:0]   MAG_MAX    = {MAG_W{1'b1}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_SAMPLES - 1);
  localparam logic [CLIP_W-1:0]  CLIP_LAST  = CLIP_W'(CLIP_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DECAY
  } chState_t;

  chState_t            r_state    [NUM_CH];
  logic [MAG_W-1:0]    r_peak     [NUM_CH];
  logic [HOLD_W-1:0]   r_holdCnt  [NUM_CH];
  logic [DECAY_W-1:0]  r_decayCnt [NUM_CH];
  logic [CLIP_W-1:0]   r_clipCnt  [NUM_CH];
  logic [NUM_CH-1:0]   r_clip;

  logic [DATA_W-1:0]   w_sample    [NUM_CH];
  logic [DATA_W-1:0]   w_neg       [NUM_CH];
  logic [MAG_W-1:0]    w_mag       [NUM_CH];
  logic [MAG_W-1:0]    w_step      [NUM_CH];
  logic [MAG_W-1:0]    w_decayPeak [NUM_CH];

  logic [MAG_W-1:0]    w_maxPeak;
  logic [MAG_W-1:0]    w_chPeak;
  logic [MAG_W-1:0]    w_disp;
  logic [NUM_LEDS-1:0] w_thermo;

  // Per-channel magnitude and next decayed peak. Negating the most negative
  // sample gives itself back (sign bit still set), which is how the
  // saturation case is recognised. The decay step never drops below 1 so a
  // small peak still reaches zero in finite time.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_sample[c] = audio_in[c*DATA_W +: DATA_W];
      w_neg[c]    = (~w_sample[c]) + DATA_W'(1);
      if (!w_sample[c][DATA_W-1]) begin
        w_mag[c] = w_sample[c][MAG_W-1:0];
      end else if (w_neg[c][DATA_W-1]) begin
        w_mag[c] = MAG_MAX;
      end else begin
        w_mag[c] = w_neg[c][MAG_W-1:0];
      end
      w_step[c] = r_peak[c] >> DECAY_SHIFT;
      if (w_step[c] == '0) begin
        w_step[c] = MAG_W'(1);
      end
      w_decayPeak[c] = r_peak[c] - w_step[c];
    end
  end

  // Channel state: peak capture / hold / decay FSM plus the clip timer.
  // A new peak overrides whatever the FSM would otherwise do this sample.
  // Clear wipes the channel state the same way reset does, and a sample
  // arriving alongside clear is discarded.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset || clear) begin
        r_state[c]    <= S_IDLE;
        r_peak[c]     <= '0;
        r_holdCnt[c]  <= '0;
        r_decayCnt[c] <= '0;
        r_clipCnt[c]  <= '0;
        r_clip[c]     <= 1'b0;
      end else if (audio_valid) begin
        if (w_mag[c] > r_peak[c]) begin
          r_peak[c]     <= w_mag[c];
          r_holdCnt[c]  <= HOLD_LAST;
          r_decayCnt[c] <= '0;
          r_state[c]    <= S_HOLD;
        end else begin
          case (r_state[c])
            S_HOLD: begin
              if (r_holdCnt[c] == '0) begin
                r_state[c] <= S_DECAY;
              end else begin
                r_holdCnt[c] <= r_holdCnt[c] - HOLD_W'(1);
              end
            end
            S_DECAY: begin
              if (r_decayCnt[c] == DECAY_LAST) begin
                r_decayCnt[c] <= '0;
                r_peak[c]     <= w_decayPeak[c];
                if (w_decayPeak[c] == '0) begin
                  r_state[c] <= S_IDLE;
                end
              end else begin
                r_decayCnt[c] <= r_decayCnt[c] + DECAY_W'(1);
              end
            end
            default: begin
            end
          endcase
        end

        if (w_mag[c] == MAG_MAX) begin
          r_clip[c]    <= 1'b1;
          r_clipCnt[c] <= CLIP_LAST;
        end else if (r_clip[c]) begin
          if (r_clipCnt[c] == '0) begin
            r_clip[c] <= 1'b0;
          end else begin
            r_clipCnt[c] <= r_clipCnt[c] - CLIP_W'(1);
          end
        end
      end
    end
  end

  // Display source selection and thermometer decode. A disp_ch that names
  // no channel matches nothing in the loop and leaves the bar dark.
  always_comb begin
    w_maxPeak = '0;
    w_chPeak  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_peak[c] > w_maxPeak) begin
        w_maxPeak = r_peak[c];
      end
      if (CH_W'(c) == disp_ch) begin
        w_chPeak = r_peak[c];
      end
    end
    w_disp = disp_max ? w_maxPeak : w_chPeak;
    for (int k = 0; k < NUM_LEDS; k++) begin
      w_thermo[k] = (w_disp >= (MAG_W'(1) << (BASE_BIT + k)));
    end
  end

  // Output registers, refreshed every cycle so display selection changes
  // show up one cycle later regardless of audio_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_level <= '0;
      peak_out  <= '0;
    end else begin
      led_level <= w_thermo;
      peak_out  <= w_disp;
    end
  end

  assign clip = r_clip;

endmodule

// File: tb/tb_peak_meter_mc.sv
// ---------------------------------------------------------------------------
// tb_peak_meter_mc
// Directed self-checking bench for peak_meter_mc with default parameters
// (2 channels, 32-bit samples, 10 LEDs from bit 19, hold 4800, decay every
// 48 samples by peak>>4, clip hold 24000). Inputs change 1 time unit after
// the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_peak_meter_mc;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] audio_in;
  logic        audio_valid;
  logic        clear;
  logic        disp_max;
  logic [0:0]  disp_ch;
  logic [9:0]  led_level;
  logic [30:0] peak_out;
  logic [1:0]  clip;

  int checks = 0;
  int errors = 0;

  peak_meter_mc dut (
    .clock       (clock),
    .reset       (reset),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .clear       (clear),
    .disp_max    (disp_max),
    .disp_ch     (disp_ch),
    .led_level   (led_level),
    .peak_out    (peak_out),
    .clip        (clip)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one sample frame for n consecutive valid cycles, then go idle.
  task automatic applyStimulus(input logic [31:0] ch0, input logic [31:0] ch1, input int n);
    audio_in    = {ch1, ch0};
    audio_valid = 1'b1;
    repeat (n) tick();
    audio_valid = 1'b0;
    audio_in    = '0;
  endtask

  task automatic silent(input int n);
    applyStimulus(32'h0, 32'h0, n);
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic checkLed(input string tag, input logic [9:0] expLed);
    checks++;
    assert (led_level === expLed) else begin
      errors++;
      $error("[TB] FAIL %s led_level observed %h expected %h", tag, led_level, expLed);
    end
  endtask

  task automatic checkPeak(input string tag, input logic [30:0] expPeak);
    checks++;
    assert (peak_out === expPeak) else begin
      errors++;
      $error("[TB] FAIL %s peak_out observed %h expected %h", tag, peak_out, expPeak);
    end
  endtask

  task automatic checkClip(input string tag, input logic [1:0] expClip);
    checks++;
    assert (clip === expClip) else begin
      errors++;
      $error("[TB] FAIL %s clip observed %b expected %b", tag, clip, expClip);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expLed,
                             input logic [30:0] expPeak, input logic [1:0] expClip);
    checkLed(tag, expLed);
    checkPeak(tag, expPeak);
    checkClip(tag, expClip);
  endtask

  initial begin
    logic [30:0] model;
    logic [30:0] step;
    int          steps;

    reset       = 1'b1;
    clear       = 1'b0;
    disp_max    = 1'b1;
    disp_ch     = 1'b0;
    audio_valid = 1'b1;

    // Reset held two cycles with random samples and valid strobes
    for (int i = 0; i < 2; i++) begin
      audio_in = {$urandom(), $urandom()};
      tick();
      checkOutput("reset_hold", 10'h000, 31'h0, 2'b00);
    end
    reset       = 1'b0;
    audio_valid = 1'b0;
    audio_in    = '0;
    tick();
    checkOutput("reset_idle", 10'h000, 31'h0, 2'b00);

    // Just below LED0 threshold, and the N+1 latency point
    applyStimulus(32'h0007_FFFF, 32'h0, 1);
    checkOutput("lat_n1", 10'h000, 31'h0, 2'b00);
    tick();
    checkOutput("below_led0", 10'h000, 31'h0007_FFFF, 2'b00);

    // Exactly LED0 threshold
    applyStimulus(32'h0008_0000, 32'h0, 1);
    tick();
    checkOutput("led0_edge", 10'h001, 31'h0008_0000, 2'b00);

    // ch1 = -0x1000_0000 fills the bar through max-of-channels
    applyStimulus(32'h0, 32'hF000_0000, 1);
    tick();
    checkOutput("neg_full_bar", 10'h3FF, 31'h1000_0000, 2'b00);

    doClear();
    checkOutput("clear_basic", 10'h000, 31'h0, 2'b00);

    // Most negative sample saturates and clips; clip lasts 24000 silent valids
    applyStimulus(32'h8000_0000, 32'h0, 1);
    tick();
    checkOutput("clip_set", 10'h3FF, 31'h7FFF_FFFF, 2'b01);
    silent(23999);
    tick();
    checkClip("clip_hold", 2'b01);
    silent(1);
    checkClip("clip_drop", 2'b00);

    // Positive full scale also clips
    doClear();
    applyStimulus(32'h0, 32'h7FFF_FFFF, 1);
    checkClip("clip_posmax", 2'b10);
    doClear();
    checkClip("clip_cleared", 2'b00);

    // Hold for 4800 valids, first decay step at valid 4848, then walk to 0
    applyStimulus(32'h1000_0000, 32'h0, 1);
    silent(4800);
    tick();
    checkPeak("hold_end", 31'h1000_0000);
    silent(47);
    tick();
    checkPeak("decay_pre", 31'h1000_0000);
    silent(1);
    tick();
    checkOutput("decay_step1", 10'h1FF, 31'h0F00_0000, 2'b00);
    model = 31'h0F00_0000;
    steps = 0;
    while (model != 31'h0 && steps < 2000) begin
      step = model >> 4;
      if (step == 31'h0) step = 31'h1;
      model = model - step;
      silent(48);
      tick();
      checkPeak("decay_walk", model);
      steps++;
    end
    checkOutput("decay_zero", 10'h000, 31'h0, 2'b00);
    applyStimulus(32'h1, 32'h0, 1);
    tick();
    checkPeak("idle_rearm", 31'h1);
    doClear();

    // Clear mid-DECAY together with a louder sample: sample is dropped
    applyStimulus(32'h1000_0000, 32'h0, 1);
    silent(4810);
    tick();
    checkPeak("mid_decay", 31'h1000_0000);
    clear       = 1'b1;
    audio_valid = 1'b1;
    audio_in    = {32'h0, 32'h2000_0000};
    tick();
    clear       = 1'b0;
    audio_valid = 1'b0;
    audio_in    = '0;
    checkPeak("clear_n1", 31'h1000_0000);
    tick();
    checkOutput("clear_n2", 10'h000, 31'h0, 2'b00);
    tick();
    checkPeak("clear_drop", 31'h0);

    // Channel selection
    disp_max = 1'b0;
    disp_ch  = 1'b1;
    applyStimulus(32'h0010_0000, 32'h0200_0000, 1);
    tick();
    checkOutput("sel_ch1", 10'h07F, 31'h0200_0000, 2'b00);
    disp_ch = 1'b0;
    tick();
    checkOutput("sel_ch0", 10'h003, 31'h0010_0000, 2'b00);
    disp_max = 1'b1;
    tick();
    checkLed("sel_max", 10'h07F);
    disp_max = 1'b0;
    doClear();

    // Equal magnitude does not re-arm hold; idle gaps freeze the counters
    applyStimulus(32'h0100_0000, 32'h0, 1);
    applyStimulus(32'hFF00_0000, 32'h0, 1);
    silent(3999);
    repeat (500) tick();
    silent(847);
    tick();
    checkPeak("freeze_pre", 31'h0100_0000);
    silent(1);
    tick();
    checkOutput("freeze_step", 10'h01F, 31'h00F0_0000, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
